id_stage: RTL

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
// Instruction decode stage for RV32I/RV64I.
// One-entry registered pipeline slot with valid/ready handshakes on both sides.
// The decoded bundle is computed combinationally from the incoming word and
// captured on an accepted transfer, so every out_* signal is a flop.
module id_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_alu_op,
  output logic            out_word_op,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_illegal
);

  localparam logic IS64 = (XLEN == 64);

  // Major opcodes
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_FENCE     = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  // ALU operation codes seen by execute
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // Map funct3 (plus the instr[30] alternate bit) to an ALU operation.
  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Raw instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign rd     = in_instr[11:7];

  // Immediates, all sign-extended from instr[31]; shift amounts zero-extended
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt6, shamt5;
  assign imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
  assign imm_u  = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
  assign imm_j  = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
  assign shamt6 = {{(XLEN-6){1'b0}}, in_instr[25:20]};
  assign shamt5 = {{(XLEN-5){1'b0}}, in_instr[24:20]};

  // funct7 qualifiers; on RV64 the OP-IMM shift field leaves instr[25] to shamt
  logic f7_zero, f7_alt, slli_ok, srxi_ok;
  assign f7_zero = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);
  assign slli_ok = IS64 ? (in_instr[31:26] == 6'b000000) : f7_zero;
  assign srxi_ok = IS64 ? ((in_instr[31:26] == 6'b000000) ||
                           (in_instr[31:26] == 6'b010000)) : (f7_zero || f7_alt);

  // Decoded bundle for the word currently presented on in_instr
  logic [XLEN-1:0] dec_imm;
  logic [3:0]      dec_alu_op;
  logic            dec_word_op, dec_reg_write, dec_mem_read, dec_mem_write;
  logic            dec_branch, dec_jump, dec_illegal;

  // Combinational decode; illegal paths leave every field at its zero default
  always_comb begin
    dec_imm       = '0;
    dec_alu_op    = ALU_ADD;
    dec_word_op   = 1'b0;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_branch    = 1'b0;
    dec_jump      = 1'b0;
    dec_illegal   = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec_imm       = imm_u;
        dec_alu_op    = ALU_PASSB;
        dec_reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec_imm       = imm_u;
        dec_reg_write = 1'b1;
      end
      OPC_JAL: begin
        dec_imm       = imm_j;
        dec_reg_write = 1'b1;
        dec_jump      = 1'b1;
      end
      OPC_JALR: begin
        if (funct3 != 3'b000) begin
          dec_illegal = 1'b1;
        end else begin
          dec_imm       = imm_i;
          dec_reg_write = 1'b1;
          dec_jump      = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if (funct3 == 3'b010 || funct3 == 3'b011) begin
          dec_illegal = 1'b1;
        end else begin
          dec_imm    = imm_b;
          dec_alu_op = ALU_SUB;
          dec_branch = 1'b1;
        end
      end
      OPC_LOAD: begin
        if (funct3 == 3'b111 || (!IS64 && (funct3 == 3'b011 || funct3 == 3'b110))) begin
          dec_illegal = 1'b1;
        end else begin
          dec_imm       = imm_i;
          dec_reg_write = 1'b1;
          dec_mem_read  = 1'b1;
        end
      end
      OPC_STORE: begin
        if (funct3[2] || (!IS64 && funct3 == 3'b011)) begin
          dec_illegal = 1'b1;
        end else begin
          dec_imm       = imm_s;
          dec_mem_write = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        if (funct3 == 3'b001) begin
          dec_illegal   = !slli_ok;
          dec_imm       = IS64 ? shamt6 : shamt5;
          dec_alu_op    = ALU_SLL;
          dec_reg_write = 1'b1;
        end else if (funct3 == 3'b101) begin
          dec_illegal   = !srxi_ok;
          dec_imm       = IS64 ? shamt6 : shamt5;
          dec_alu_op    = alu_sel(funct3, in_instr[30]);
          dec_reg_write = 1'b1;
        end else begin
          dec_imm       = imm_i;
          dec_alu_op    = alu_sel(funct3, 1'b0);
          dec_reg_write = 1'b1;
        end
      end
      OPC_OP: begin
        if (f7_zero || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          dec_alu_op    = alu_sel(funct3, in_instr[30]);
          dec_reg_write = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_FENCE: begin
        // Ordering is trivially satisfied in this pipeline: behaves as a NOP.
      end
      OPC_OP_IMM_32: begin
        if (!IS64) begin
          dec_illegal = 1'b1;
        end else if (funct3 == 3'b000) begin
          dec_imm       = imm_i;
          dec_word_op   = 1'b1;
          dec_reg_write = 1'b1;
        end else if ((funct3 == 3'b001 && f7_zero) ||
                     (funct3 == 3'b101 && (f7_zero || f7_alt))) begin
          dec_imm       = shamt5;
          dec_alu_op    = alu_sel(funct3, in_instr[30]);
          dec_word_op   = 1'b1;
          dec_reg_write = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_OP_32: begin
        if (IS64 && ((funct3 == 3'b001 && f7_zero) ||
                     ((funct3 == 3'b000 || funct3 == 3'b101) && (f7_zero || f7_alt)))) begin
          dec_alu_op    = alu_sel(funct3, in_instr[30]);
          dec_word_op   = 1'b1;
          dec_reg_write = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      default: begin
        // Unknown opcodes, SYSTEM, and any word with instr[1:0] != 2'b11
        dec_illegal = 1'b1;
      end
    endcase
    // An illegal word is presented with no side effects at all
    if (dec_illegal) begin
      dec_imm       = '0;
      dec_alu_op    = ALU_ADD;
      dec_word_op   = 1'b0;
      dec_reg_write = 1'b0;
    end
    // Writes to x0 are discarded here so execute never has to check rd
    if (rd == 5'd0) begin
      dec_reg_write = 1'b0;
    end
  end

  logic take;
  assign in_ready = !out_valid || out_ready;
  assign take     = in_valid && in_ready && !flush;

  // Pipeline register: flush wins over capture, bundle holds while stalled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_rd        <= '0;
      out_rs1       <= '0;
      out_rs2       <= '0;
      out_funct3    <= '0;
      out_imm       <= '0;
      out_alu_op    <= '0;
      out_word_op   <= 1'b0;
      out_reg_write <= 1'b0;
      out_mem_read  <= 1'b0;
      out_mem_write <= 1'b0;
      out_branch    <= 1'b0;
      out_jump      <= 1'b0;
      out_illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (take) begin
      out_valid     <= 1'b1;
      out_pc        <= in_pc;
      out_rd        <= rd;
      out_rs1       <= in_instr[19:15];
      out_rs2       <= in_instr[24:20];
      out_funct3    <= funct3;
      out_imm       <= dec_imm;
      out_alu_op    <= dec_alu_op;
      out_word_op   <= dec_word_op;
      out_reg_write <= dec_reg_write;
      out_mem_read  <= dec_mem_read;
      out_mem_write <= dec_mem_write;
      out_branch    <= dec_branch;
      out_jump      <= dec_jump;
      out_illegal   <= dec_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
